// File: rtl/eth_playback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_playback_pkg : slot layout, FSM states and address composition.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package eth_playback_pkg;

  localparam int STATUS_OFF       = 48;
  localparam int CHUNK_BYTES      = 64;
  localparam int FIRST_DATA_CHUNK = 1;
  localparam int BURST_MAX        = CHUNK_BYTES / 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_DATA   = 2'd2,
    ST_RETIRE = 2'd3
  } pb_state_e;

  // Shared with the capture path: window(10) slot(10) chunk(6) off(6)
  function automatic logic [31:0] slot_addr(input logic [9:0] window,
                                            input logic [9:0] slot,
                                            input logic [5:0] chunk,
                                            input logic [5:0] off);
    return {window, slot, chunk, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_playback_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_playback_if : memory read request/beat bus plus transmit byte stream.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface eth_playback_if;

  logic [31:0] mr_addr;
  logic [3:0]  mr_len;
  logic        mr_req;
  logic        mr_ack;
  logic [31:0] mr_data;
  logic        mr_valid;
  logic [7:0]  txdata;
  logic        txvalid;
  logic        txeop;
  logic        txready;

  modport master (
    output mr_addr, mr_len, mr_req,
    input  mr_ack, mr_data, mr_valid,
    output txdata, txvalid, txeop,
    input  txready
  );

  modport slave (
    input  mr_addr, mr_len, mr_req,
    output mr_ack, mr_data, mr_valid,
    input  txdata, txvalid, txeop,
    output txready
  );

endinterface
`default_nettype wire

// File: rtl/pkt_words_to_bytes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkt_words_to_bytes : serialises FIFO words into little-endian bytes.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pkt_words_to_bytes (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] bytecount,
  input  logic [31:0] word,
  input  logic        word_avail,
  input  logic        txready,
  output logic [7:0]  txdata,
  output logic        txvalid,
  output logic        txeop,
  output logic        pop,
  output logic        last_accepted
);

  logic        active_q, active_d;
  logic [11:0] idx_q, idx_d;
  logic        at_last;
  logic        accept;
  logic [7:0]  lane_byte;

  // Outputs derive only from flops and the FIFO head, so they hold during stalls
  always_comb begin
    case (idx_q[1:0])
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
    at_last       = (idx_q == (bytecount - 12'd1));
    txvalid       = active_q & word_avail;
    txeop         = txvalid & at_last;
    txdata        = txvalid ? lane_byte : 8'd0;
    accept        = txvalid & txready;
    pop           = accept & ((idx_q[1:0] == 2'd3) | at_last);
    last_accepted = accept & at_last;

    active_d = active_q;
    idx_d    = idx_q;
    if (start) begin
      active_d = 1'b1;
      idx_d    = 12'd0;
    end else if (accept) begin
      idx_d = idx_q + 12'd1;
      if (at_last) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      idx_q    <= 12'd0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_playback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_playback : fetches packets from a ring of 4 KB slots and streams bytes.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module eth_playback
  import eth_playback_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          MAX_BYTES   = 4032,
  parameter int          WFIFO_DEPTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [9:0]     tail,
  output logic [9:0]     head,
  eth_playback_if.master bus,
  output logic           tx_done,
  output logic           tx_err
);

  localparam int         AW     = $clog2(WFIFO_DEPTH);
  localparam int         CW     = AW + 1;
  localparam logic [9:0] WINDOW = BASE_ADDR[31:22];

  pb_state_e   state_q, state_d;
  logic [9:0]  head_q, head_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [11:0] bytecount_q, bytecount_d;
  logic        err_q, err_d;
  logic [5:0]  chunk_q, chunk_d;
  logic [10:0] words_left_q, words_left_d;
  logic [CW-1:0] outst_q, outst_d;

  logic [31:0]   fifo_mem [WFIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          fifo_wr, fifo_rd, fifo_full, fifo_empty;

  logic [11:0] hdr_bcount;
  logic        hdr_bad;
  logic [10:0] hdr_words;
  logic        data_ack, credit_ok, fetch_ok;
  logic [3:0]  burst_len;
  logic        w2b_start, w2b_last;
  logic [7:0]  w2b_data;
  logic        w2b_valid, w2b_eop;

  assign hdr_bcount = bus.mr_data[11:0];
  assign hdr_bad    = (hdr_bcount == 12'd0) || (32'(hdr_bcount) > 32'(MAX_BYTES));
  assign hdr_words  = 11'(({1'b0, hdr_bcount} + 13'd3) >> 2);
  assign data_ack   = (state_q == ST_DATA) && req_q && bus.mr_ack;
  assign fifo_wr    = (state_q == ST_DATA) && bus.mr_valid;
  assign fifo_full  = (fifo_cnt_q == CW'(WFIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  // Credit counts beats already promised to us, so a burst never overruns the FIFO
  assign credit_ok  = (32'(fifo_cnt_q) + 32'(outst_q) + 32'(BURST_MAX)) <= 32'(WFIFO_DEPTH);
  assign fetch_ok   = (state_q == ST_DATA) && !req_q && (words_left_q != 11'd0) && credit_ok;
  assign burst_len  = (words_left_q >= 11'(BURST_MAX)) ? 4'(BURST_MAX - 1)
                                                       : 4'(words_left_q - 11'd1);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable && (head_q != tail)) state_d = ST_HDR;
      ST_HDR:    if (bus.mr_valid) state_d = hdr_bad ? ST_RETIRE : ST_DATA;
      ST_DATA:   if (w2b_last) state_d = ST_RETIRE;
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.mr_req  = req_q;
    bus.mr_addr = addr_q;
    bus.mr_len  = len_q;
    bus.txdata  = w2b_data;
    bus.txvalid = w2b_valid;
    bus.txeop   = w2b_eop;
    tx_done     = (state_q == ST_RETIRE);
    tx_err      = (state_q == ST_RETIRE) && err_q;
    head        = head_q;
  end

  always_comb begin
    head_d       = head_q;
    req_d        = req_q;
    addr_d       = addr_q;
    len_d        = len_q;
    bytecount_d  = bytecount_q;
    err_d        = err_q;
    chunk_d      = chunk_q;
    words_left_d = words_left_q;
    w2b_start    = 1'b0;
    if (req_q && bus.mr_ack) req_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_HDR) begin
          req_d  = 1'b1;
          addr_d = slot_addr(WINDOW, head_q, 6'd0, 6'(STATUS_OFF));
          len_d  = 4'd0;
          err_d  = 1'b0;
        end
      end
      ST_HDR: begin
        if (bus.mr_valid) begin
          bytecount_d = hdr_bcount;
          if (hdr_bad) begin
            err_d = 1'b1;
          end else begin
            words_left_d = hdr_words;
            chunk_d      = 6'(FIRST_DATA_CHUNK);
            w2b_start    = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (data_ack) begin
          chunk_d      = chunk_q + 6'd1;
          words_left_d = words_left_q - (11'(len_q) + 11'd1);
        end
        if (fetch_ok) begin
          req_d  = 1'b1;
          addr_d = slot_addr(WINDOW, head_q, chunk_q, 6'd0);
          len_d  = burst_len;
        end
      end
      ST_RETIRE: head_d = head_q + 10'd1;
      default: ;
    endcase

    outst_d = outst_q;
    if (data_ack) outst_d = outst_d + CW'(len_q) + CW'(1);
    if (fifo_wr)  outst_d = outst_d - CW'(1);

    wr_ptr_d   = fifo_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= 10'd0;
      req_q        <= 1'b0;
      addr_q       <= 32'd0;
      len_q        <= 4'd0;
      bytecount_q  <= 12'd0;
      err_q        <= 1'b0;
      chunk_q      <= 6'd0;
      words_left_q <= 11'd0;
      outst_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      head_q       <= head_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      bytecount_q  <= bytecount_d;
      err_q        <= err_d;
      chunk_q      <= chunk_d;
      words_left_q <= words_left_d;
      outst_q      <= outst_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= bus.mr_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(fifo_wr && fifo_full));

  pkt_words_to_bytes u_w2b (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (w2b_start),
    .bytecount     (bytecount_q),
    .word          (fifo_mem[rd_ptr_q]),
    .word_avail    (!fifo_empty),
    .txready       (bus.txready),
    .txdata        (w2b_data),
    .txvalid       (w2b_valid),
    .txeop         (w2b_eop),
    .pop           (fifo_rd),
    .last_accepted (w2b_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_eth_playback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_playback : randomized memory/transmitter environment and scoreboard.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_eth_playback;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] tail = 10'd0;
  logic [9:0] head;
  logic       tx_done, tx_err;

  eth_playback_if bus ();

  eth_playback dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tail    (tail),
    .head    (head),
    .bus     (bus),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } req_t;

  bit [31:0]   mem [bit [31:0]];
  req_t        exp_reqs [$];
  logic [8:0]  exp_bytes [$];
  bit          exp_done [$];
  logic [31:0] beatq [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          rdy_mode = 0;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_tx = 10'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] slot_base(input int s);
    return BASE + 32'(s) * 32'd4096;
  endfunction

  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    bit [31:0] w;
    w = {a[31:2], 2'b00};
    return mem.exists(w) ? mem[w] : 32'd0;
  endfunction

  task automatic fill_slot(input int s, input int bc);
    mem[slot_base(s) + 32'd48] = ($urandom() & 32'hFFFF_F000) | 32'(bc);
    if (bc <= 4032)
      for (int i = 0; i < (bc + 3) / 4; i++) mem[slot_base(s) + 32'd64 + 32'(4 * i)] = $urandom();
  endtask

  // Expected traffic for one slot: payload is contiguous bytes starting at slot+64
  task automatic expect_slot(input int s);
    bit [31:0] b;
    int bc, words, ch, n;
    b  = slot_base(s);
    bc = int'(mem_rd(b + 32'd48) & 32'hFFF);
    exp_reqs.push_back('{addr: b + 32'd48, len: 4'd0});
    if (bc == 0 || bc > 4032) begin
      exp_done.push_back(1'b1);
      return;
    end
    words = (bc + 3) / 4;
    ch = 1;
    while (words > 0) begin
      n = (words > 16) ? 16 : words;
      exp_reqs.push_back('{addr: b + 32'(64 * ch), len: 4'(n - 1)});
      words -= n;
      ch++;
    end
    for (int i = 0; i < bc; i++)
      exp_bytes.push_back({i == bc - 1, 8'(mem_rd(b + 32'(64 + i)) >> (8 * (i % 4)))});
    exp_done.push_back(1'b0);
  endtask

  task automatic flush_model();
    exp_reqs.delete();
    exp_bytes.delete();
    exp_done.delete();
    beatq.delete();
  endtask

  task automatic tick();
    logic       acc;
    logic [9:0] cur;
    req_t       r;
    @(negedge clk);
    cur = {bus.txvalid, bus.txeop, bus.txdata};
    if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_tx));
    case (rdy_mode)
      0:       bus.txready = 1'b1;
      1:       bus.txready = ~bus.txready;
      default: bus.txready = ($urandom_range(0, 9) < 7);
    endcase
    acc        = bus.txvalid & bus.txready;
    prev_stall = bus.txvalid & ~bus.txready;
    prev_tx    = cur;
    if (acc) begin
      n_acc++;
      if (exp_bytes.size() == 0) check("extra_byte", 32'(acc), 32'd0);
      else check("byte", 32'({bus.txeop, bus.txdata}), 32'(exp_bytes.pop_front()));
    end
    if (tx_err && !tx_done) check("err_without_done", 32'(tx_err), 32'd0);
    if (tx_done) begin
      if (exp_done.size() == 0) check("extra_done", 32'(tx_done), 32'd0);
      else check("done_err", 32'(tx_err), 32'(exp_done.pop_front()));
    end
    if (beatq.size() != 0 && $urandom_range(0, 3) != 0) begin
      bus.mr_valid = 1'b1;
      bus.mr_data  = beatq.pop_front();
    end else begin
      bus.mr_valid = 1'b0;
      bus.mr_data  = $urandom();
    end
    bus.mr_ack = 1'b0;
    if (bus.mr_req && $urandom_range(0, 3) != 0) begin
      bus.mr_ack = 1'b1;
      if (exp_reqs.size() == 0) begin
        check("extra_req", 32'(bus.mr_req), 32'd0);
      end else begin
        r = exp_reqs.pop_front();
        check("req_addr", bus.mr_addr, r.addr);
        check("req_len", 32'(bus.mr_len), 32'(r.len));
      end
      for (int i = 0; i <= int'(bus.mr_len); i++) beatq.push_back(mem_rd(bus.mr_addr + 32'(4 * i)));
    end
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_reqs.size() + exp_bytes.size() + exp_done.size() + beatq.size()) != 0 && c < budget) begin
      tick();
      c++;
    end
    check("drain_left", 32'(exp_reqs.size() + exp_bytes.size() + exp_done.size()), 32'd0);
    flush_model();
    repeat (3) tick();
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_txvalid"}, 32'(bus.txvalid), 32'd0);
    check({tag, "_txeop"}, 32'(bus.txeop), 32'd0);
    check({tag, "_txdata"}, 32'(bus.txdata), 32'd0);
    check({tag, "_mr_req"}, 32'(bus.mr_req), 32'd0);
    check({tag, "_tx_done"}, 32'(tx_done), 32'd0);
    check({tag, "_head"}, 32'(head), 32'd0);
  endtask

  initial begin
    int c, a0;
    bus.mr_ack   = 1'b0;
    bus.mr_valid = 1'b0;
    bus.mr_data  = 32'd0;
    bus.txready  = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet_outputs("reset");
    check("reset_mr_addr", bus.mr_addr, 32'd0);
    check("reset_mr_len", 32'(bus.mr_len), 32'd0);
    reset_n = 1'b1;

    // Slot 0: five bytes, posted while disabled so nothing may start yet
    mem[slot_base(0) + 32'd48] = 32'd5;
    mem[slot_base(0) + 32'd64] = 32'h4433_2211;
    mem[slot_base(0) + 32'd68] = 32'h0000_0055;
    tail = 10'd1;
    repeat (10) tick();
    expect_slot(0);
    enable = 1'b1;
    drain(500);
    check("head_after_5B", 32'(head), 32'd1);

    fill_slot(1, 100);
    expect_slot(1);
    tail = 10'd2;
    drain(2000);
    check("head_after_100B", 32'(head), 32'd2);

    rdy_mode = 1;
    fill_slot(2, 64);
    expect_slot(2);
    tail = 10'd3;
    drain(2000);
    check("head_after_64B", 32'(head), 32'd3);

    fill_slot(3, 0);
    fill_slot(4, 4033);
    expect_slot(3);
    expect_slot(4);
    tail = 10'd5;
    drain(500);
    check("head_after_bad", 32'(head), 32'd5);

    // Back-to-back random packets including the largest legal length
    rdy_mode = 2;
    for (int s = 5; s <= 10; s++) begin
      fill_slot(s, (s == 10) ? 4032 : int'($urandom_range(1, 300)));
      expect_slot(s);
    end
    tail = 10'd11;
    drain(30000);
    check("head_after_random", 32'(head), 32'd11);

    // Dropping enable mid-packet finishes the current slot only
    fill_slot(11, int'($urandom_range(60, 200)));
    fill_slot(12, int'($urandom_range(1, 50)));
    expect_slot(11);
    tail = 10'd13;
    a0 = n_acc;
    c = 0;
    while (n_acc == a0 && c < 2000) begin
      tick();
      c++;
    end
    enable = 1'b0;
    drain(3000);
    repeat (30) tick();
    check("head_enable_low", 32'(head), 32'd12);
    enable = 1'b1;
    expect_slot(12);
    drain(1000);
    check("head_enable_high", 32'(head), 32'd13);

    // Empty slots up to 1022 retire as malformed, then slot 1023 wraps head to 0
    for (int s = 13; s <= 1022; s++) expect_slot(s);
    fill_slot(1023, 8);
    expect_slot(1023);
    tail = 10'd0;
    drain(40000);
    repeat (20) tick();
    check("head_wrapped", 32'(head), 32'd0);

    // Asynchronous reset in the middle of a 100-byte packet
    fill_slot(0, 100);
    expect_slot(0);
    tail = 10'd1;
    a0 = n_acc;
    c = 0;
    while (n_acc < a0 + 20 && c < 2000) begin
      tick();
      c++;
    end
    check("bytes_before_reset", 32'(n_acc - a0 >= 20), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_quiet_outputs("async_rst");
    flush_model();
    bus.mr_valid = 1'b0;
    bus.mr_ack   = 1'b0;
    prev_stall   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_slot(0);
    drain(2000);
    check("head_after_resend", 32'(head), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
